// File: rtl/test_exit_monitor.sv
// Passive snooper on the data-memory bus that detects the test-exit store and latches pass/fail plus the run length.
// Optional watchdog: define TEST_EXIT_TIMEOUT_EN to end a silent run after TIMEOUT_CYCLES cycles.
module test_exit_monitor #(
    parameter int                XLEN           = 64,
    parameter logic [XLEN-1:0]   EXIT_ADDR      = 'h1000,
    parameter logic [31:0]       WDATA_SUCCESS  = 32'd1,
    parameter logic [63:0]       TIMEOUT_CYCLES = 64'd1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic                mem_ready,
    input  logic                mem_wen,
    input  logic [XLEN-1:0]     mem_addr,
    input  logic [XLEN-1:0]     mem_wdata,
    input  logic [XLEN/8-1:0]   mem_wmask,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [30:0]         fail_testnum,
    output logic [63:0]         cycle_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2,
        TMO  = 2'd3
    } state_t;

    state_t state;
    logic   hit;
    logic   wdog_expire;

    // valid/ready: a request transfers only on an edge where both are high; this block
    // observes that transfer and never drives or stalls either signal.
    assign hit = mem_valid && mem_ready && mem_wen
              && (mem_addr == EXIT_ADDR) && (mem_wmask[3:0] == 4'hF);

`ifdef TEST_EXIT_TIMEOUT_EN
    assign wdog_expire = (cycle_count == (TIMEOUT_CYCLES - 64'd1));
    logic unused_bits;
    assign unused_bits = ^{mem_wdata[XLEN-1:32], mem_wmask[XLEN/8-1:4]};
`else
    assign wdog_expire = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{mem_wdata[XLEN-1:32], mem_wmask[XLEN/8-1:4], TIMEOUT_CYCLES};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            cycle_count  <= 64'd0;
            fail_testnum <= 31'd0;
        end else if (state == RUN) begin
            if (cycle_count != {64{1'b1}}) begin
                cycle_count <= cycle_count + 64'd1;
            end
            // A hit outranks watchdog expiry on the same edge.
            if (hit) begin
                if (mem_wdata[31:0] == WDATA_SUCCESS) begin
                    state <= PASS;
                end else begin
                    state        <= FAIL;
                    fail_testnum <= mem_wdata[31:1];
                end
            end else if (wdog_expire) begin
                state <= TMO;
            end
        end
    end

    assign done    = (state != RUN);
    assign pass    = (state == PASS);
    assign timeout = (state == TMO);

endmodule

// File: tb/tb_test_exit_monitor.sv
// Directed bench for test_exit_monitor: a small bus-level model pushes expected exit results
// into a queue and each is compared when the monitor reports done.
module tb_test_exit_monitor;
  localparam int XLEN = 64;
  localparam int W    = 97;  // {pass, timeout, fail_testnum, cycle_count}
  localparam int TMO_CYCLES = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_valid = 1'b0;
  logic              mem_ready = 1'b0;
  logic              mem_wen = 1'b0;
  logic [XLEN-1:0]   mem_addr = '0;
  logic [XLEN-1:0]   mem_wdata = '0;
  logic [XLEN/8-1:0] mem_wmask = '0;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [30:0]       fail_testnum;
  logic [63:0]       cycle_count;

  always #5 clk = ~clk;

  test_exit_monitor #(
    .XLEN          (XLEN),
    .EXIT_ADDR     (64'h1000),
    .WDATA_SUCCESS (32'd1),
    .TIMEOUT_CYCLES(64'(TMO_CYCLES))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .fail_testnum (fail_testnum),
    .cycle_count  (cycle_count)
  );

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int unsigned  m_edges = 0;
  bit           m_done = 1'b0;
  bit           m_timeout = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Assert reset mid-cycle, check outputs clear without a clock edge, then release on a negedge.
  task automatic reset_dut();
    #2;
    rst = 1'b1;
    mem_valid = 1'b0;
    mem_wen = 1'b0;
    #1;
    check("reset_outputs", W'({done, pass, timeout, fail_testnum, cycle_count}), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_edges = 0;
    m_done = 1'b0;
    m_timeout = 1'b0;
    exp_q.delete();
  endtask

  task automatic step(input logic v, input logic r, input logic wen,
                      input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    logic hit;
    logic ok;
    mem_valid = v;
    mem_ready = r;
    mem_wen   = wen;
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    @(posedge clk);
    hit = v && r && wen && (a == 64'h1000) && (m[3:0] == 4'hF);
    if (!m_done) begin
      m_edges++;
      if (hit) begin
        ok = (d[31:0] == 32'd1);
        m_done = 1'b1;
        exp_q.push_back({ok, 1'b0, ok ? 31'd0 : d[31:1], 64'(m_edges)});
      end
`ifdef TEST_EXIT_TIMEOUT_EN
      else if (m_edges == TMO_CYCLES) begin
        m_done = 1'b1;
        m_timeout = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 31'd0, 64'(TMO_CYCLES)});
      end
`endif
    end
    #1;
    mem_valid = 1'b0;
    mem_wen   = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    mem_addr  = {32'd0, $urandom};
    mem_wdata = {$urandom, $urandom};
    mem_wmask = 8'($urandom_range(0, 255));
    check("done", W'(done), W'(m_done));
    check("timeout", W'(timeout), W'(m_timeout));
    check("cycle_count", W'(cycle_count), W'(m_edges));
    if (exp_q.size() > 0) begin
      check("result", {pass, timeout, fail_testnum, cycle_count}, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
  endtask

  initial begin
    // Pass on the 10th edge after reset release; upper data bits ignored.
    reset_dut();
    idle(9);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    // Later stores are ignored once terminal.
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h7, 8'hFF);
    idle(2);

    // Reset pulsed in PASS, then a fresh run passes.
    reset_dut();
    idle(3);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h1, 8'h0F);
    idle(1);

    // Test 3 fails; a later success store does not change the verdict.
    reset_dut();
    idle(2);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h7, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h1, 8'hFF);
    idle(1);

    // Non-hits: stalled handshake, load, wrong address, partial masks; then the real handshake.
    reset_dut();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 64'h1000, 64'h1, 8'hFF);
    step(1'b1, 1'b1, 1'b0, 64'h1000, 64'h1, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 64'h1008, 64'h1, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h1, 8'h03);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h1, 8'hF0);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h1, 8'h0F);
    idle(1);

    // Value 0 is a fail with test number 0.
    reset_dut();
    idle(4);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h0, 8'hFF);

    // Only the low word decides: 0x80000001 fails as test 0x40000000.
    reset_dut();
    idle(1);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'hFFFF_FFFF_8000_0001, 8'hFF);

    // Silent run past the watchdog limit (timeout only when the watchdog is built).
    reset_dut();
    idle(TMO_CYCLES + 5);

    // Hit on the edge where the watchdog would expire: the hit wins.
    reset_dut();
    idle(TMO_CYCLES - 1);
    step(1'b1, 1'b1, 1'b1, 64'h1000, 64'h1, 8'hFF);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/test_exit_monitor.md
# test_exit_monitor

Passive snooper on the core's data-memory bus, used in test builds. It detects the test-exit store to the configured exit address and decides pass or fail. It latches the result and cycle count for the simulation top to end the run. It drives nothing on the bus. In non-test builds it is instantiated with its outputs left unused.

## Interface
- `XLEN`, 64, bus address/data width.
- `EXIT_ADDR`, 'h1000, byte address of the exit word. Driven from the test-exit-address config constant.
- `WDATA_SUCCESS`, 1, 32-bit value that signals pass. Driven from the success-value config constant.
- `TIMEOUT_CYCLES`, 1_000_000, watchdog limit. Used only when the watchdog is compiled in.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  request valid (snooped).
- `mem_ready`  in  1  request ready (snooped).
- `mem_wen`  in  1  request is a store.
- `mem_addr`  in  XLEN  byte address.
- `mem_wdata`  in  XLEN  store data.
- `mem_wmask`  in  XLEN/8  byte-enable mask.
- `done`  out  1  run finished (sticky).
- `pass`  out  1  valid when `done` is high. 1 = success.
- `timeout`  out  1  run ended by the watchdog (sticky).
- `fail_testnum`  out  31  failing test number, equal to `wdata[31:1]`. Zero on pass or timeout.
- `cycle_count`  out  64  cycles since reset release. Frozen once `done` is high.

## Operation
- Accepted exit store (`hit`): `mem_valid & mem_ready & mem_wen & (mem_addr == EXIT_ADDR) & (mem_wmask[3:0] == 4'hF)`.
  - Only the low 32 bits of `mem_wdata` are examined. Upper bytes and mask bits are ignored.
  - A store with a partial low-word mask, or a load to `EXIT_ADDR`, is not a hit.
- The FSM has four states: `RUN` (reset state), `PASS`, `FAIL`, `TMO`.
- `RUN` to `PASS`: on a hit with `wdata[31:0] == WDATA_SUCCESS`.
- `RUN` to `FAIL`: on a hit with any other value. The store is latched and `fail_testnum = wdata[31:1]`.
  - Value 0 counts as a fail, with `fail_testnum = 0`.
- `RUN` to `TMO`: when the watchdog expires (see Configuration).
- `PASS`, `FAIL` and `TMO` are terminal. Only `rst` leaves them. Later hits are ignored, so the first hit wins.
- Outputs are decoded from the state register:
  - `done = (state != RUN)`
  - `pass = (state == PASS)`
  - `timeout = (state == TMO)`
- `cycle_count` increments by 1 every cycle in `RUN`.
  - It saturates at 2^64−1 and does not wrap.
  - It holds its value in the terminal states.
- The bus handshake is never stalled or altered by this block.

## Timing
- Reset values of every output: `done` 0, `pass` 0, `timeout` 0, `fail_testnum` 0, `cycle_count` 0. The state is `RUN`.
- Assertion of `rst` at any point, including in terminal states, immediately clears all state.
- Hit latency: a hit sampled at edge N makes `done`, `pass` and `fail_testnum` visible after edge N.
  - They are registered, one cycle after the handshake cycle.
- `cycle_count` at done equals the number of `RUN` edges, including the hit edge.
  - Example: a hit on the 10th edge after reset release gives `cycle_count` = 10.
- If a hit and watchdog expiry occur on the same edge, the hit wins (`PASS` or `FAIL`).
- A hit with `valid` high and `ready` low does nothing. Only the handshake edge counts.

## Configuration
- Macro `TEST_EXIT_TIMEOUT_EN`.
- Defined: a watchdog compares `cycle_count` against `TIMEOUT_CYCLES − 1` in `RUN`.
  - A match with no hit moves the FSM to `TMO`. Then `done` = 1, `pass` = 0, `timeout` = 1 and `cycle_count` = `TIMEOUT_CYCLES`.
- Undefined: no comparator is built, `TMO` is unreachable, `timeout` is tied to 0, and the run can last indefinitely.

## Test plan
- Reset release, then a store of 1 to 'h1000 with mask 'hFF on the 10th edge -> one cycle later `done` = 1, `pass` = 1, `fail_testnum` = 0, `cycle_count` = 10.
- Store of 'h7 (test 3 failed) -> `done` = 1, `pass` = 0, `fail_testnum` = 3. A later store of 1 leaves `pass` = 0.
- Exit address held with `valid` = 1 and `ready` = 0 for 5 cycles, then `ready` = 1 -> `done` only after the handshake. A load to 'h1000, a store to 'h1008, and a store with mask 'h03 -> no `done`.
- With `TEST_EXIT_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20, no store -> `timeout` = 1, `done` = 1, `cycle_count` = 20. A hit on the expiry edge -> `pass` = 1, `timeout` = 0.
- `rst` pulsed while in `PASS` -> all outputs 0 immediately. A new run then passes normally.
